// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the flagged FIFO family.
package fifo_pkg;

    // Width of the saturating error counter (optional FIFO_ERR_CNT_EN build).
    localparam int ERR_CNT_W = 8;

    // Read-port behaviour: registered pop vs. first-word-fall-through.
    typedef enum logic {
        FIFO_REG  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // Pointer width; depth is a power of two >= 2, so this is at least 1.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy width: one extra bit so that 0..depth is representable.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for the flagged FIFO: synchronous write, asynchronous read.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int width = 8,
    parameter int depth = 8
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [ptr_w(depth)-1:0]  wr_addr,
    input  logic [width-1:0]         wr_data,
    input  logic [ptr_w(depth)-1:0]  rd_addr,
    output logic [width-1:0]         rd_data
);

    logic [width-1:0] mem [depth];

    // Store the incoming word at the write address.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_flagged.sv
// Synchronous FIFO with occupancy count, almost-full/almost-empty flags and a
// selectable read mode (fwft = 0 registered pop, fwft = 1 fall-through).
// Optional build macro FIFO_ERR_CNT_EN adds sticky overflow/underflow flags
// and a saturating error counter.
module fifo_flagged
    import fifo_pkg::*;
#(
    parameter int width    = 8,
    parameter int depth    = 8,
    parameter int af_level = depth - 2,
    parameter int ae_level = 2,
    parameter int fwft     = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     read,
    input  logic                     write,
    input  logic [width-1:0]         data,
    output logic [width-1:0]         queue_data,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_empty,
    output logic                     almost_full,
    output logic [cnt_w(depth)-1:0]  count
`ifdef FIFO_ERR_CNT_EN
    ,
    output logic                     overflow,
    output logic                     underflow,
    output logic [ERR_CNT_W-1:0]     err_count
`endif
);

    localparam int         PW   = ptr_w(depth);
    localparam int         CW   = cnt_w(depth);
    localparam fifo_mode_e MODE = (fwft != 0) ? FIFO_FWFT : FIFO_REG;

    localparam logic [CW-1:0] DEPTH_C = CW'(depth);
    localparam logic [CW-1:0] AF_C    = CW'(af_level);
    localparam logic [CW-1:0] AE_C    = CW'(ae_level);

    // Reject configurations whose flags or pointer wrap would be meaningless.
    if ((depth < 2) || ((depth & (depth - 1)) != 0)) begin : g_bad_depth
        $error("fifo_flagged: depth must be a power of two >= 2");
    end
    if (af_level > depth) begin : g_bad_af
        $error("fifo_flagged: af_level must not exceed depth");
    end
    if (ae_level >= depth) begin : g_bad_ae
        $error("fifo_flagged: ae_level must be below depth");
    end

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    rd_ptr_next;
    logic [PW-1:0]    rd_addr;
    logic [CW-1:0]    count_next;
    logic [width-1:0] rd_data;
    logic [width-1:0] fwd_data;
    logic             read_acc;
    logic             write_acc;
    logic             mem_we;

    // Handshake decode: a pop frees a slot, so a full FIFO may still accept
    // a write in the same cycle; a read on empty is never accepted.
    always_comb begin
        read_acc    = read && !empty;
        write_acc   = write && (!full || read_acc);
        rd_ptr_next = read_acc ? rd_ptr + 1'b1 : rd_ptr;
        count_next  = count + CW'(write_acc) - CW'(read_acc);
        mem_we      = write_acc && !rst;
    end

    // Fall-through mode looks ahead to the post-edge head; registered mode
    // reads the current head when a pop is taken.
    always_comb begin
        rd_addr  = (MODE == FIFO_FWFT) ? rd_ptr_next : rd_ptr;
        fwd_data = rd_data;
        if (write_acc && (wr_ptr == rd_ptr_next)) begin
            fwd_data = data;
        end
    end

    fifo_mem #(
        .width (width),
        .depth (depth)
    ) u_mem (
        .clk     (clk),
        .wr_en   (mem_we),
        .wr_addr (wr_ptr),
        .wr_data (data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Pointer update; pointers wrap naturally since depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (write_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_ptr_next;
        end
    end

    // Occupancy and flags, all registered from the next count so they line
    // up with the pointer update.
    always_ff @(posedge clk) begin
        if (rst) begin
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= (AF_C == '0);
        end else begin
            count        <= count_next;
            empty        <= (count_next == '0);
            full         <= (count_next == DEPTH_C);
            almost_empty <= (count_next <= AE_C);
            almost_full  <= (count_next >= AF_C);
        end
    end

    // Output word register: holds its value whenever nothing new is shown.
    always_ff @(posedge clk) begin
        if (rst) begin
            queue_data <= '0;
        end else if (MODE == FIFO_FWFT) begin
            if (count_next != '0) begin
                queue_data <= fwd_data;
            end
        end else if (read_acc) begin
            queue_data <= rd_data;
        end
    end

`ifdef FIFO_ERR_CNT_EN
    logic ovf_evt;
    logic unf_evt;

    // A dropped write needs full with no pop; an ignored read needs empty.
    always_comb begin
        ovf_evt = write && full && !read_acc;
        unf_evt = read && empty;
    end

    // Sticky error flags and saturating event counter, cleared only by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
            err_count <= '0;
        end else begin
            if (ovf_evt) begin
                overflow <= 1'b1;
            end
            if (unf_evt) begin
                underflow <= 1'b1;
            end
            if ((ovf_evt || unf_evt) && (err_count != '1)) begin
                err_count <= err_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_flagged.sv
// Directed bench for fifo_flagged: one registered-read and one fall-through
// instance share the same stimulus.
module tb_fifo_flagged;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       read = 1'b0;
    logic       write = 1'b0;
    logic [7:0] data = '0;

    logic [7:0] qd0, qd1;
    logic       empty0, full0, ae0, af0;
    logic       empty1, full1, ae1, af1;
    logic [3:0] count0, count1;
`ifdef FIFO_ERR_CNT_EN
    logic       ovf0, unf0, ovf1, unf1;
    logic [7:0] ec0, ec1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_flagged #(.width(8), .depth(8), .fwft(0)) dut_reg (
        .clk(clk), .rst(rst), .read(read), .write(write), .data(data),
        .queue_data(qd0), .empty(empty0), .full(full0),
        .almost_empty(ae0), .almost_full(af0), .count(count0)
`ifdef FIFO_ERR_CNT_EN
        , .overflow(ovf0), .underflow(unf0), .err_count(ec0)
`endif
    );

    fifo_flagged #(.width(8), .depth(8), .fwft(1)) dut_fwft (
        .clk(clk), .rst(rst), .read(read), .write(write), .data(data),
        .queue_data(qd1), .empty(empty1), .full(full1),
        .almost_empty(ae1), .almost_full(af1), .count(count1)
`ifdef FIFO_ERR_CNT_EN
        , .overflow(ovf1), .underflow(unf1), .err_count(ec1)
`endif
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One clock with the given request; outputs are stable #1 after the edge.
    task automatic op(input logic r, input logic w, input logic [7:0] d);
        read  = r;
        write = w;
        data  = d;
        @(posedge clk);
        #1;
        read  = 1'b0;
        write = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        op(1'b0, 1'b0, 8'd0);
        rst = 1'b0;
    endtask

    int vals [7] = '{100, 150, 200, 40, 70, 65, 15};

    initial begin
        // Reset state
        do_reset();
        check("rst_count", count0, 0);
        check("rst_empty", empty0, 1);
        check("rst_full", full0, 0);
        check("rst_ae", ae0, 1);
        check("rst_af", af0, 0);
        check("rst_qd", qd0, 0);
        check("rst_qd_fwft", qd1, 0);

        // Seven writes, then in-order reads
        for (int i = 0; i < 7; i++) op(1'b0, 1'b1, 8'(vals[i]));
        check("w7_count", count0, 7);
        check("w7_af", af0, 1);
        check("w7_full", full0, 0);
        check("w7_ae", ae0, 0);
        check("w7_count_fwft", count1, 7);
        for (int i = 0; i < 7; i++) begin
            check("fwft_head", qd1, vals[i]);
            op(1'b1, 1'b0, 8'd0);
            check("reg_pop", qd0, vals[i]);
        end
        check("r7_empty", empty0, 1);
        check("r7_count", count0, 0);
        check("r7_fwft_hold", qd1, 15);
        for (int i = 0; i < 3; i++) begin
            op(1'b1, 1'b0, 8'd0);
            check("rd_empty_qd", qd0, 15);
            check("rd_empty_flag", empty0, 1);
        end

        // Fill, then write on full is dropped
        for (int i = 1; i <= 8; i++) op(1'b0, 1'b1, 8'(i));
        check("fill_full", full0, 1);
        check("fill_count", count0, 8);
        op(1'b0, 1'b1, 8'd99);
        check("drop_full", full0, 1);
        check("drop_count", count0, 8);
        for (int i = 1; i <= 8; i++) begin
            op(1'b1, 1'b0, 8'd0);
            check("drain_pop", qd0, i);
        end
        check("drain_empty", empty0, 1);

        // Read+write while full
        for (int i = 1; i <= 8; i++) op(1'b0, 1'b1, 8'(i));
        op(1'b1, 1'b1, 8'd50);
        check("rw_full_count", count0, 8);
        check("rw_full_flag", full0, 1);
        check("rw_full_pop", qd0, 1);
        check("rw_full_fwft_head", qd1, 2);
        for (int i = 2; i <= 8; i++) begin
            op(1'b1, 1'b0, 8'd0);
            check("rw_full_drain", qd0, i);
        end
        op(1'b1, 1'b0, 8'd0);
        check("rw_full_last", qd0, 50);
        check("rw_full_empty", empty0, 1);

        // Read+write while empty: only the write is taken
        op(1'b1, 1'b1, 8'd7);
        check("rw_empty_count", count0, 1);
        check("rw_empty_flag", empty0, 0);
        check("rw_empty_reg_hold", qd0, 50);
        check("rw_empty_fwft_qd", qd1, 7);
        check("rw_empty_fwft_count", count1, 1);

        // Reset mid-operation, with requests active in the reset cycle
        for (int i = 0; i < 3; i++) op(1'b0, 1'b1, 8'(11 + i));
        check("pre_rst_count", count0, 4);
        rst = 1'b1;
        op(1'b1, 1'b1, 8'd33);
        rst = 1'b0;
        check("mid_rst_empty", empty0, 1);
        check("mid_rst_count", count0, 0);
        check("mid_rst_qd", qd0, 0);
        check("mid_rst_qd_fwft", qd1, 0);
        op(1'b1, 1'b0, 8'd0);
        check("post_rst_empty", empty0, 1);
        check("post_rst_count", count0, 0);
        check("post_rst_qd", qd0, 0);

`ifdef FIFO_ERR_CNT_EN
        do_reset();
        check("err_rst_ec", ec0, 0);
        for (int i = 1; i <= 8; i++) op(1'b0, 1'b1, 8'(i));
        op(1'b0, 1'b1, 8'd90);
        op(1'b0, 1'b1, 8'd91);
        check("ovf_set", ovf0, 1);
        check("unf_clear", unf0, 0);
        check("ec_two", ec0, 2);
        for (int i = 1; i <= 8; i++) op(1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 3; i++) op(1'b1, 1'b0, 8'd0);
        check("ovf_sticky", ovf0, 1);
        check("unf_set", unf0, 1);
        check("ec_five", ec0, 5);
        check("ec_five_fwft", ec1, 5);
        do_reset();
        check("ovf_rst", ovf0, 0);
        check("unf_rst", unf0, 0);
        check("ec_rst", ec0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_flagged.md
Name: fifo_flagged

Overview:
- Next-generation synchronous FIFO: parametrised width/depth, occupancy count, programmable almost-full/almost-empty flags, and a selectable first-word-fall-through (FWFT) read mode.
- Drop-in successor for the existing buffer between pipeline stages and peripheral queues. Single clock domain.

Parameters:
- width, 8, data word width in bits (>=1)
- depth, 8, number of entries; power of two, >=2
- af_level, depth-2, almost_full asserts when count >= af_level
- ae_level, 2, almost_empty asserts when count <= ae_level
- fwft, 0, 0 = registered-read mode, 1 = first-word-fall-through mode

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- read  in  1  pop request
- write  in  1  push request
- data  in  width  write data
- queue_data  out  width  read data
- empty  out  1  no entries
- full  out  1  depth entries
- almost_empty  out  1  count <= ae_level
- almost_full  out  1  count >= af_level
- count  out  $clog2(depth)+1  current occupancy, 0..depth

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst), sampled on the rising edge.
- Reset values: rd/wr pointers 0, count 0, queue_data 0, empty 1, full 0, almost_empty 1, almost_full 0 (for af_level > 0).
- Pointers are $clog2(depth) bits and wrap naturally from depth-1 to 0. count is tracked separately, so full and empty are unambiguous.
- Push accepted: write && (!full || read_accepted). Pop accepted: read && !empty.
- Simultaneous read+write:
  - When full: both accepted; count unchanged; full stays 1.
  - When empty: write accepted, read ignored; count becomes 1.
- Write on full without read: dropped; memory, pointer and count unchanged.
- Read on empty: ignored; queue_data holds its previous value.
- All flags and count are registered and derived from next-count, so they are valid in the same cycle as the pointer update.
- fwft=0 (registered-read mode):
  - queue_data is loaded with mem[rd_ptr] on the edge where a pop is accepted, so it is valid after that edge.
  - queue_data holds between pops.
- fwft=1 (first-word-fall-through mode):
  - queue_data always shows mem[rd_ptr] while !empty; read acknowledges and advances.
  - The first word appears one cycle after its write into an empty FIFO.
  - While empty, queue_data holds the last value shown.
- Reset mid-operation: all contents are logically discarded, pointers and count return to 0 on the reset edge, and read/write are ignored in that cycle.
- Elaboration-time checks: depth not a power of two, af_level > depth, or ae_level >= depth -> $error.

Optional Feature:
- Macro: FIFO_ERR_CNT_EN.
- When defined, adds outputs:
  - overflow (sticky): set by a write dropped on full.
  - underflow (sticky): set by a read ignored on empty.
  - err_count (8 bits): saturating count of both events, saturates at 255.
  - All three are cleared only by rst.
- When undefined, these ports and their logic are absent and the core behaviour is identical.

Decomposition:
- Package fifo_pkg holds:
  - the count/pointer width helper functions (ptr_w(depth), cnt_w(depth));
  - the localparam ERR_CNT_W = 8;
  - the read-mode enum fifo_mode_e {FIFO_REG, FIFO_FWFT}.
- One sub-module, fifo_mem: simple dual-port array, width x depth, with synchronous write and an asynchronous read port. Flag, pointer and output-register logic stay in fifo_flagged.

Test Plan:
- Reset, then write 100,150,200,40,70,65,15 (depth 8, fwft=0) -> count=7, almost_full=1, full=0; 7 reads return 100,150,200,40,70,65,15 in order; 3 further reads keep queue_data=15 and empty=1.
- Fill to 8 entries (values 1..8), then write 99 without read -> 99 dropped, full=1, count=8; next 8 reads return 1..8.
- Full, then read+write of 50 in the same cycle -> count stays 8, first read returns 1, and 50 is read out last.
- Empty, then read+write of 7 in the same cycle -> count=1, empty=0; with fwft=1, queue_data=7 one cycle later, before any read.
- Write 3 words, assert rst for one cycle, then read -> empty=1, count=0, queue_data=0, and the read is ignored.
- With FIFO_ERR_CNT_EN defined: 2 writes on full, then 3 reads on empty -> overflow=1, underflow=1, err_count=5; after rst all three are 0.
